// File: rtl/im_boot_loader.sv
// im_boot_loader: loads a header + big-endian instruction bytes into the IM and holds the core in reset until the image is complete.
// Optional trailer checksum check: define IMLOAD_CHECKSUM_EN.
module im_boot_loader #(
    parameter int IM_DEPTH    = 32,
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, HDR, COLLECT, WRITE, DONE, ERROR
`ifdef IMLOAD_CHECKSUM_EN
        , CHECK
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, last_q, last_d, im_addr_q, im_addr_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       acc_q, acc_d, im_wdata_q, im_wdata_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              timed, accept;
`ifdef IMLOAD_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign timed = state_q == HDR || state_q == COLLECT
`ifdef IMLOAD_CHECKSUM_EN
        || state_q == CHECK
`endif
        ;
    assign accept     = byte_valid && byte_ready;
    assign byte_ready = timed;
    assign busy       = timed || state_q == WRITE;
    assign im_we      = state_q == WRITE;
    assign cpu_reset  = state_q != DONE;
    assign done       = state_q == DONE;
    assign error      = state_q == ERROR;
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        bcnt_d     = bcnt_q;
        acc_d      = acc_q;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        tmo_d      = timed ? (accept ? '0 : tmo_q + TW'(1)) : tmo_q;
`ifdef IMLOAD_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = HDR;
                    tmo_d   = '0;
`ifdef IMLOAD_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            HDR: begin
                if (accept) begin
                    state_d = 32'(byte_data) > IM_DEPTH ? ERROR : COLLECT;
                    last_d  = byte_data == 8'd0 ? ADDR_W'(IM_DEPTH - 1) : ADDR_W'(byte_data - 8'd1);
                    idx_d   = '0;
                    bcnt_d  = '0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    acc_d  = {acc_q[23:0], byte_data};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef IMLOAD_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        state_d    = WRITE;
                        im_addr_d  = idx_q;
                        im_wdata_d = acc_d;
                    end
                end
            end
            WRITE: begin
                if (idx_q == last_q) begin
`ifdef IMLOAD_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    bcnt_d  = '0;
                    state_d = COLLECT;
                end
            end
`ifdef IMLOAD_CHECKSUM_EN
            CHECK: begin
                if (accept) state_d = byte_data == csum_q ? DONE : ERROR;
            end
`endif
            default: state_d = IDLE;
        endcase
        // an accept on the expiring edge keeps the load alive
        if (timed && !accept && tmo_d == TW'(TIMEOUT_CYC - 1)) state_d = ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            bcnt_q     <= '0;
            acc_q      <= '0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            tmo_q      <= '0;
`ifdef IMLOAD_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            bcnt_q     <= bcnt_d;
            acc_q      <= acc_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            tmo_q      <= tmo_d;
`ifdef IMLOAD_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_im_boot_loader.sv
// tb_im_boot_loader: scoreboard bench; stimulus queues expected IM writes, a monitor pops and compares each im_we pulse.
module tb_im_boot_loader;
    localparam int TIMEOUT_CYC = 1024;

    logic        clk = 0, reset = 1, start = 0, byte_valid = 0;
    logic [7:0]  byte_data = 0;
    logic        byte_ready, im_we, cpu_reset, busy, done, error;
    logic [4:0]  im_addr;
    logic [31:0] im_wdata;

    int asserts = 0, fails = 0, we_cnt = 0, addr0_cnt = 0;
    logic [31:0] last_wdata = 0;
    logic [4:0]  exp_a[$];
    logic [31:0] exp_d[$];
    logic [7:0]  img[$];

    im_boot_loader #(.IM_DEPTH(32), .ADDR_W(5), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        asserts++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (im_we) begin
            we_cnt++;
            last_wdata = im_wdata;
            if (im_addr == 5'd0) addr0_cnt++;
            if (exp_a.size() == 0) chk("unexpected_we", {27'd0, im_addr}, 32'hFFFFFFFF);
            else begin
                chk("we_addr", {27'd0, im_addr}, {27'd0, exp_a.pop_front()});
                chk("we_data", im_wdata, exp_d.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1;
        byte_data  = b;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1 byte_valid = 0;
    endtask

    task automatic do_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic send_img(input logic [7:0] hdr, input bit gaps);
        for (int k = 0; k + 3 < img.size(); k += 4) begin
            exp_a.push_back(5'(k / 4));
            exp_d.push_back({img[k], img[k+1], img[k+2], img[k+3]});
        end
        send(hdr, 0);
        foreach (img[i]) send(img[i], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_end_bound", n < 2000, 1);
    endtask

    function automatic logic [7:0] xsum();
        logic [7:0] x = 0;
        foreach (img[i]) x ^= img[i];
        return x;
    endfunction

    initial begin
        int w;
        repeat (2) @(negedge clk);
        reset = 0;
        chk("rst_ready", byte_ready, 0);
        chk("rst_we", im_we, 0);
        chk("rst_addr", {27'd0, im_addr}, 0);
        chk("rst_wdata", im_wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_flags", {busy, done, error}, 0);
        repeat (10) @(negedge clk);
        chk("idle_hold", {byte_ready, im_we, cpu_reset, busy, done, error}, 6'b001000);

        img = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        do_start();
        chk("start_busy", {busy, byte_ready}, 2'b11);
        w = we_cnt;
        send_img(8'h02, 0);
`ifdef IMLOAD_CHECKSUM_EN
        send(8'h25, 0);
`else
        @(negedge clk);
`endif
        @(negedge clk);
        chk("t2_done", done, 1);
        chk("t2_cpu_reset", cpu_reset, 0);
        chk("t2_busy", busy, 0);
        chk("t2_we_count", we_cnt - w, 2);
`ifdef IMLOAD_CHECKSUM_EN
        do_start();
        chk("t2b_cpu_reset_back", cpu_reset, 1);
        send_img(8'h02, 0);
        send(8'h00, 0);
        @(negedge clk);
        chk("t2b_error", error, 1);
        chk("t2b_cpu_reset", cpu_reset, 1);
`endif

        img = {};
        for (int i = 0; i < 128; i++) img.push_back(8'(i));
        do_start();
        w = we_cnt;
        addr0_cnt = 0;
        send_img(8'h00, 0);
`ifdef IMLOAD_CHECKSUM_EN
        send(xsum(), 0);
`endif
        wait_end();
        chk("t3_done", done, 1);
        chk("t3_we_count", we_cnt - w, 32);
        chk("t3_last_word", last_wdata, 32'h7C7D7E7F);
        chk("t3_addr0_once", addr0_cnt, 1);

        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_start();
        w = we_cnt;
        send_img(8'h03, 0);
        repeat (TIMEOUT_CYC) @(negedge clk);
        chk("t4_error", error, 1);
        chk("t4_cpu_reset", cpu_reset, 1);
        chk("t4_we_count", we_cnt - w, 1);
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        do_start();
        send_img(8'h03, 0);
`ifdef IMLOAD_CHECKSUM_EN
        send(xsum(), 0);
`endif
        wait_end();
        chk("t4_reload_done", {done, error}, 2'b10);

        img = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        do_start();
        w = we_cnt;
        send_img(8'h02, 1);
`ifdef IMLOAD_CHECKSUM_EN
        send(8'h25, 2);
`endif
        wait_end();
        chk("t5_done", {done, error}, 2'b10);
        chk("t5_we_count", we_cnt - w, 2);

        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_start();
        send_img(8'h02, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("t6_reset_state", {byte_ready, cpu_reset, busy, done, error}, 5'b01000);
        do_start();
        w = we_cnt;
        send(8'h21, 0);
        @(negedge clk);
        chk("t6_bad_hdr_error", error, 1);
        chk("t6_cpu_reset", cpu_reset, 1);
        repeat (5) @(negedge clk);
        chk("t6_no_we", we_cnt - w, 0);
        chk("scoreboard_empty", exp_a.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
